fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches to instruction memory,
// buffers returned words in a small prefetch queue and presents the queue
// head to decode. A redirect flushes the queue and restarts fetching at the
// new address, draining any request the memory has already accepted.
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;

   state_t             state;
   state_t             next_state;
   logic [31:0]        fetch_pc;
   logic [31:0]        req_addr;
   logic [31:0]        pc_q   [DEPTH];
   logic [31:0]        data_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               issue_stall;
   logic               do_push;
   logic               do_pop;

   // Queue status and the push/pop qualifiers; a redirect overrides both.
   always_comb begin
      full        = (count == CNT_W'(DEPTH));
      issue_stall = (state == FETCH) && !full && !mem_ack;
      do_push     = mem_req && mem_ack && !redirect &&
                    ((state == FETCH) || (state == WAIT));
      do_pop      = instr_valid && instr_ready && !redirect;
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic: an unacknowledged request that gets redirected must
   // still be drained so its late data is not mistaken for the new stream.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = FETCH;
         FETCH:   if (issue_stall) next_state = redirect ? DRAIN : WAIT;
         WAIT:    if (mem_ack) next_state = FETCH;
                  else if (redirect) next_state = DRAIN;
         DRAIN:   if (mem_ack) next_state = FETCH;
         default: next_state = IDLE;
      endcase
   end

   // Memory-side outputs; an outstanding request holds its captured address.
   always_comb begin
      mem_req  = ((state == FETCH) && !full) || (state == WAIT) || (state == DRAIN);
      mem_addr = ((state == WAIT) || (state == DRAIN)) ? req_addr : fetch_pc;
   end

   // Fetch address: redirect wins, otherwise advance one word per accepted fetch.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)        fetch_pc <= RESET_PC;
      else if (redirect) fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (do_push)  fetch_pc <= fetch_pc + 32'd4;
   end

   // Capture the address of a request that was not acknowledged immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)           req_addr <= RESET_PC;
      else if (issue_stall) req_addr <= fetch_pc;
   end

   // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

   // Queue storage; contents only matter while occupancy covers them.
   always_ff @(posedge clock) begin
      if (do_push) begin
         pc_q[wr_ptr]   <= fetch_pc;
         data_q[wr_ptr] <= mem_rdata;
      end
   end

   // Head of queue to decode, forced to zero when the queue is empty.
   always_comb begin
      instr_valid = (count != '0);
      instr       = instr_valid ? data_q[rd_ptr] : 32'h0;
      instr_pc    = instr_valid ? pc_q[rd_ptr]   : 32'h0;
   end

endmodule
